// File: rtl/cpu_bus_master.sv
// Bus initiator for the 17-bit address / 16-bit data CPU local bus.
// Turns single read/write commands into SETUP/STROBE/HOLD bus cycles and returns a one-cycle response.
module cpu_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,  // legal 1..255
  parameter int unsigned STROBE_CYC = 3,  // legal 2..255
  parameter int unsigned HOLD_CYC   = 1   // legal 1..255
) (
  input  logic        CpuClk,
  input  logic        RstCpu,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic        CmdWr,
  input  logic [16:0] CmdAddr,
  input  logic [15:0] CmdWrData,
  output logic        RspValid,
  output logic        RspWr,
  output logic [15:0] RspRdData,
  output logic        CpuCs_n,
  output logic        CpuWr_n,
  output logic        CpuRd_n,
  output logic [16:0] CpuAddr,
  output logic [15:0] CpuData_out,
  input  logic [15:0] CpuData_in,
  output logic [15:0] TxnCnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);

  state_t      state, state_nxt;
  logic [7:0]  phase_cnt, phase_cnt_nxt;
  logic        txn_wr, txn_wr_nxt;
  logic        cs_n_nxt, wr_n_nxt, rd_n_nxt;
  logic [16:0] addr_nxt;
  logic [15:0] data_out_nxt;
  logic        rsp_valid_nxt, rsp_wr_nxt;
  logic [15:0] rsp_rd_data_nxt;
  logic [15:0] txn_cnt, txn_cnt_nxt;
  logic        phase_done;

  assign CmdReady   = (state == IDLE);
  assign TxnCnt     = txn_cnt;
  assign phase_done = (phase_cnt == 8'd0);

  // Every pin is computed here and registered below, so no Cmd* input reaches a Cpu* pin combinationally.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_nxt       = state;
    phase_cnt_nxt   = phase_cnt;
    txn_wr_nxt      = txn_wr;
    cs_n_nxt        = CpuCs_n;
    wr_n_nxt        = CpuWr_n;
    rd_n_nxt        = CpuRd_n;
    addr_nxt        = CpuAddr;
    data_out_nxt    = CpuData_out;
    rsp_valid_nxt   = 1'b0;
    rsp_wr_nxt      = RspWr;
    rsp_rd_data_nxt = RspRdData;
    txn_cnt_nxt     = txn_cnt;

    unique case (state)
      IDLE: begin
        if (CmdValid) begin
          addr_nxt      = CmdAddr;
          if (CmdWr) data_out_nxt = CmdWrData;
          txn_wr_nxt    = CmdWr;
          cs_n_nxt      = 1'b0;
          phase_cnt_nxt = SETUP_LOAD;
          state_nxt     = SETUP;
        end
      end

      SETUP: begin
        if (phase_done) begin
          wr_n_nxt      = ~txn_wr;
          rd_n_nxt      = txn_wr;
          phase_cnt_nxt = STROBE_LOAD;
          state_nxt     = STROBE;
        end else begin
          phase_cnt_nxt = phase_cnt - 8'd1;
        end
      end

      STROBE: begin
        if (phase_done) begin
          wr_n_nxt      = 1'b1;
          rd_n_nxt      = 1'b1;
          // The responder's data has been registered for several cycles by now, so sample it as the strobe lifts.
          if (!txn_wr) rsp_rd_data_nxt = CpuData_in;
          phase_cnt_nxt = HOLD_LOAD;
          state_nxt     = HOLD;
        end else begin
          phase_cnt_nxt = phase_cnt - 8'd1;
        end
      end

      HOLD: begin
        if (phase_done) begin
          cs_n_nxt      = 1'b1;
          rsp_valid_nxt = 1'b1;
          rsp_wr_nxt    = txn_wr;
          txn_cnt_nxt   = txn_cnt + 16'd1;
          state_nxt     = IDLE;
        end else begin
          phase_cnt_nxt = phase_cnt - 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CpuClk or posedge RstCpu) begin
    if (RstCpu) begin
      state       <= IDLE;
      phase_cnt   <= 8'd0;
      txn_wr      <= 1'b0;
      CpuCs_n     <= 1'b1;
      CpuWr_n     <= 1'b1;
      CpuRd_n     <= 1'b1;
      CpuAddr     <= 17'd0;
      CpuData_out <= 16'd0;
      RspValid    <= 1'b0;
      RspWr       <= 1'b0;
      RspRdData   <= 16'd0;
      txn_cnt     <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
      state       <= state_nxt;
      phase_cnt   <= phase_cnt_nxt;
      txn_wr      <= txn_wr_nxt;
      CpuCs_n     <= cs_n_nxt;
      CpuWr_n     <= wr_n_nxt;
      CpuRd_n     <= rd_n_nxt;
      CpuAddr     <= addr_nxt;
      CpuData_out <= data_out_nxt;
      RspValid    <= rsp_valid_nxt;
      RspWr       <= rsp_wr_nxt;
      RspRdData   <= rsp_rd_data_nxt;
      txn_cnt     <= txn_cnt_nxt;
    end
  end

  // Bus protocol invariants the slave side relies on.
  a_strobes_exclusive : assert property (@(posedge CpuClk) disable iff (RstCpu)
    !(!CpuRd_n && !CpuWr_n));
  a_strobe_needs_cs : assert property (@(posedge CpuClk) disable iff (RstCpu)
    (!CpuRd_n || !CpuWr_n) |-> !CpuCs_n);

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master with a small register-file responder on the bus.
// Checks bus timing, read data, counters, back-to-back acceptance, mid-cycle reset and counter wrap.
module tb_cpu_bus_master;

  logic        CpuClk = 1'b0;
  logic        RstCpu;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdWr;
  logic [16:0] CmdAddr;
  logic [15:0] CmdWrData;
  logic        RspValid;
  logic        RspWr;
  logic [15:0] RspRdData;
  logic        CpuCs_n;
  logic        CpuWr_n;
  logic        CpuRd_n;
  logic [16:0] CpuAddr;
  logic [15:0] CpuData_out;
  logic [15:0] CpuData_in;
  logic [15:0] TxnCnt;

  cpu_bus_master dut (
    .CpuClk      (CpuClk),
    .RstCpu      (RstCpu),
    .CmdValid    (CmdValid),
    .CmdReady    (CmdReady),
    .CmdWr       (CmdWr),
    .CmdAddr     (CmdAddr),
    .CmdWrData   (CmdWrData),
    .RspValid    (RspValid),
    .RspWr       (RspWr),
    .RspRdData   (RspRdData),
    .CpuCs_n     (CpuCs_n),
    .CpuWr_n     (CpuWr_n),
    .CpuRd_n     (CpuRd_n),
    .CpuAddr     (CpuAddr),
    .CpuData_out (CpuData_out),
    .CpuData_in  (CpuData_in),
    .TxnCnt      (TxnCnt)
  );

  always #5 CpuClk = ~CpuClk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Responder: version register at 0x00003, writable soft-reset register at 0x0000B, 0xFFFF elsewhere.
  logic [15:0] soft_rst_reg = 16'h0000;

  function automatic logic [15:0] lookup(input logic [16:0] a);
    case (a)
      17'h00003: lookup = 16'h0101;
      17'h0000B: lookup = soft_rst_reg;
      default:   lookup = 16'hFFFF;
    endcase
  endfunction

  always @(posedge CpuClk) begin
    if (!CpuCs_n && !CpuWr_n && CpuAddr == 17'h0000B) soft_rst_reg <= CpuData_out;
    CpuData_in <= !CpuCs_n ? lookup(CpuAddr) : 16'h0000;
  end

  // Bus monitor, sampled on the falling edge.
  int cs_idx = 0, cs_low = 0, rd_low = 0, wr_low = 0, wr_first = 0, wr_last = 0;
  int gap_run = 0, last_gap = 0, excl_err = 0, rsp_seen = 0;

  always @(negedge CpuClk) begin
    if (!CpuRd_n && !CpuWr_n) excl_err++;
    if (CpuCs_n && (!CpuRd_n || !CpuWr_n)) excl_err++;
    if (!CpuCs_n) begin
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
      cs_idx++;
      cs_low++;
      if (!CpuRd_n) rd_low++;
      if (!CpuWr_n) begin
        wr_low++;
        if (wr_first == 0) wr_first = cs_idx;
        wr_last = cs_idx;
      end
    end else begin
      cs_idx = 0;
      gap_run++;
    end
    if (RspValid) rsp_seen++;
  end

  task automatic clear_mon();
    cs_low = 0; rd_low = 0; wr_low = 0; wr_first = 0; wr_last = 0; rsp_seen = 0;
  endtask

  // One complete transaction; returns the response fields and checks latency and pulse width.
  task automatic do_txn(input logic wr, input logic [16:0] a, input logic [15:0] d, input string tag,
                        output logic rwr, output logic [15:0] rdata);
    int n;
    @(negedge CpuClk);
    clear_mon();
    CmdValid = 1'b1; CmdWr = wr; CmdAddr = a; CmdWrData = d;
    check({tag, "_ready"}, {31'd0, CmdReady}, 32'd1);
    @(posedge CpuClk);
    @(negedge CpuClk);
    CmdValid = 1'b0;
    check({tag, "_addr"}, {15'd0, CpuAddr}, {15'd0, a});
    if (wr) check({tag, "_wdata"}, {16'd0, CpuData_out}, {16'd0, d});
    n = 1;
    while (!RspValid && n < 40) begin
      @(negedge CpuClk);
      n++;
    end
    check({tag, "_latency"}, n, 6);
    rwr   = RspWr;
    rdata = RspRdData;
    @(negedge CpuClk);
    check({tag, "_pulse1"}, {31'd0, RspValid}, 32'd0);
    #1;
  endtask

  logic        rwr;
  logic [15:0] rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RstCpu = 1'b1; CmdValid = 1'b0; CmdWr = 1'b0; CmdAddr = '0; CmdWrData = '0;
    repeat (3) @(negedge CpuClk);
    check("rst_cs",    {31'd0, CpuCs_n}, 32'd1);
    check("rst_wr",    {31'd0, CpuWr_n}, 32'd1);
    check("rst_rd",    {31'd0, CpuRd_n}, 32'd1);
    check("rst_addr",  {15'd0, CpuAddr}, 32'd0);
    check("rst_wdata", {16'd0, CpuData_out}, 32'd0);
    check("rst_rsp",   {30'd0, RspValid, RspWr}, 32'd0);
    check("rst_rdata", {16'd0, RspRdData}, 32'd0);
    check("rst_cnt",   {16'd0, TxnCnt}, 32'd0);
    check("rst_ready", {31'd0, CmdReady}, 32'd1);
    RstCpu = 1'b0;
    repeat (2) @(negedge CpuClk);

    // Version register read.
    do_txn(1'b0, 17'h00003, 16'h0000, "rd_ver", rwr, rdata);
    check("rd_ver_type", {31'd0, rwr}, 32'd0);
    check("rd_ver_data", {16'd0, rdata}, 32'h0101);
    check("rd_ver_rdlow", rd_low, 3);
    check("rd_ver_cslow", cs_low, 5);
    check("rd_ver_wrlow", wr_low, 0);
    check("rd_ver_cnt", {16'd0, TxnCnt}, 32'd1);

    // Soft-reset register write; read data must be untouched.
    do_txn(1'b1, 17'h0000B, 16'h0001, "wr_srst", rwr, rdata);
    check("wr_srst_type", {31'd0, rwr}, 32'd1);
    check("wr_srst_keep", {16'd0, rdata}, 32'h0101);
    check("wr_srst_cslow", cs_low, 5);
    check("wr_srst_wrfirst", wr_first, 2);
    check("wr_srst_wrlast", wr_last, 4);
    check("wr_srst_rdlow", rd_low, 0);
    check("wr_srst_cnt", {16'd0, TxnCnt}, 32'd2);

    do_txn(1'b0, 17'h0000B, 16'h0000, "rd_srst", rwr, rdata);
    check("rd_srst_data", {16'd0, rdata}, 32'h0001);
    check("rd_srst_cnt", {16'd0, TxnCnt}, 32'd3);

    // Unmapped address.
    do_txn(1'b0, 17'h18000, 16'h0000, "rd_unmap", rwr, rdata);
    check("rd_unmap_data", {16'd0, rdata}, 32'hFFFF);
    check("rd_unmap_cnt", {16'd0, TxnCnt}, 32'd4);

    // Back-to-back: write then read with CmdValid held.
    @(negedge CpuClk);
    CmdValid = 1'b1; CmdWr = 1'b1; CmdAddr = 17'h0000B; CmdWrData = 16'h00A5;
    @(posedge CpuClk);
    @(negedge CpuClk);
    CmdWr = 1'b0; CmdWrData = 16'h0000;
    for (int i = 0; i < 40 && !RspValid; i++) @(negedge CpuClk);
    check("b2b_rsp1", {30'd0, RspValid, RspWr}, 32'd3);
    check("b2b_ready_in_rsp", {31'd0, CmdReady}, 32'd1);
    @(negedge CpuClk);
    check("b2b_accept", {30'd0, CpuCs_n, RspValid}, 32'd0);
    CmdValid = 1'b0;
    for (int i = 0; i < 40 && !RspValid; i++) @(negedge CpuClk);
    #1;
    check("b2b_rsp2", {30'd0, RspValid, RspWr}, 32'd2);
    check("b2b_rdata", {16'd0, RspRdData}, 32'h00A5);
    check("b2b_gap", last_gap, 1);
    check("b2b_cnt", {16'd0, TxnCnt}, 32'd6);

    // Reset in the second STROBE cycle of a write.
    @(negedge CpuClk);
    clear_mon();
    CmdValid = 1'b1; CmdWr = 1'b1; CmdAddr = 17'h00010; CmdWrData = 16'h1234;
    @(posedge CpuClk);
    @(negedge CpuClk);
    CmdValid = 1'b0;
    repeat (2) @(negedge CpuClk);
    check("abort_strobe_on", {31'd0, CpuWr_n}, 32'd0);
    RstCpu = 1'b1;
    #1;
    check("abort_pins", {30'd0, CpuCs_n, CpuWr_n}, 32'd3);
    check("abort_cnt", {16'd0, TxnCnt}, 32'd0);
    repeat (3) @(negedge CpuClk);
    RstCpu = 1'b0;
    repeat (8) @(negedge CpuClk);
    check("abort_no_rsp", rsp_seen, 0);
    check("abort_cnt_after", {16'd0, TxnCnt}, 32'd0);

    do_txn(1'b0, 17'h00003, 16'h0000, "rd_after_rst", rwr, rdata);
    check("rd_after_rst_data", {16'd0, rdata}, 32'h0101);
    check("rd_after_rst_cnt", {16'd0, TxnCnt}, 32'd1);

    // Counter wrap.
    @(negedge CpuClk);
    force dut.txn_cnt = 16'hFFFF;
    #1;
    release dut.txn_cnt;
    check("wrap_pre", {16'd0, TxnCnt}, 32'hFFFF);
    do_txn(1'b1, 17'h0000B, 16'h0000, "wrap_wr", rwr, rdata);
    check("wrap_cnt", {16'd0, TxnCnt}, 32'd0);

    check("bus_invariants", excl_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
